pc_redirect_arbiter: RTL and testbench
======================================

# pc_redirect_arbiter

Sequences PC redirect requests into the superscalar fetch PC register. Three redirect sources arrive as single-cycle pulses: decode slot 1, decode slot 2 and trap. The block picks one by priority, holds it while the instruction cache is busy, and hands it to the PC through a valid/ready handshake. It also kills in-flight fetch with a flush pulse and a fetch epoch, and stalls sequential fetch while a redirect is pending.

## Interface
Parameters:
- PC_W, 64, width of all PC values.
- EPOCH_W, 3, width of fetch_epoch.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- trap_ena  in  1  trap redirect request, single-cycle pulse.
- trap_pc  in  PC_W  trap target.
- decode1_ena  in  1  decode slot 1 redirect request.
- decode1_pc  in  PC_W  slot 1 target.
- decode2_ena  in  1  decode slot 2 redirect request.
- decode2_pc  in  PC_W  slot 2 target.
- cache_un_ready  in  1  icache busy; a redirect must not be issued while this is high.
- redir_valid  out  1  redirect offered to the PC.
- redir_pc  out  PC_W  redirect target.
- redir_src  out  2  source of the held redirect: 00 none, 01 decode2, 10 decode1, 11 trap.
- redir_ready  in  1  PC accepts the redirect this cycle.
- flush_fetch  out  1  one-cycle pulse that kills in-flight fetch and instruction buffers.
- fetch_epoch  out  EPOCH_W  increments with every flush_fetch pulse; wraps modulo 2^EPOCH_W.
- stall_fetch  out  1  high while a redirect is held; the PC must not advance sequentially.
- drop_cnt  out  DROP_W  saturating count of requests that were ignored.

## Operation
- The FSM has two states, IDLE and PEND. Registers are state, held_pc, held_src, flush_q, epoch and drop_cnt.
- Reset value of every output is 0. State resets to IDLE.
- IDLE, any request present:
  - Capture the winner by priority trap > decode1 > decode2.
  - held_pc and held_src take the winner's target and code.
  - Go to PEND, set flush_q for one cycle, increment epoch.
  - Each losing request that was asserted in the same cycle increments drop_cnt; add 1 or 2 in one step, saturating at 2^DROP_W-1.
- PEND:
  - redir_valid = ~cache_un_ready.
  - redir_pc = held_pc and redir_src = held_src, stable for as long as the state is PEND.
- Handshake completes when redir_valid && redir_ready. The block then goes to IDLE with held_src = 00.
- Requests arriving in PEND:
  - decode1 and decode2 are wrong-path and are dropped; each increments drop_cnt.
  - trap when held_src != 11: overwrite held_pc and held_src, pulse flush_fetch, increment epoch. This applies even in the handshake cycle; the state then stays PEND with the trap entry. The handshaken value counts as consumed.
  - trap when held_src == 11: dropped, drop_cnt increments.
- Outputs stall_fetch = (state == PEND) and flush_fetch = flush_q.
- redir_valid, stall_fetch and redir_pc are combinational from the registers and cache_un_ready only. There is no combinational path from any *_ena to any output.
- Asserting rst mid-PEND discards the held redirect immediately and forces every output to 0.

## Timing
- Request at edge N is captured at N. From cycle N+1: stall_fetch=1, flush_fetch=1 for exactly that one cycle, fetch_epoch updated.
- redir_valid rises in cycle N+1 at the earliest, and only if cache_un_ready=0 in that cycle.
- Issue latency is 1 cycle plus the number of cycles with cache_un_ready=1 plus the number of cycles with redir_ready=0.
- Once redir_valid is high, redir_pc must not change until the handshake completes, except on a trap overwrite. redir_valid may drop if cache_un_ready rises.
- The cycle after the handshake: stall_fetch=0, redir_valid=0. A new decode request is accepted in that same cycle.
- Minimum spacing between two issued redirects with no trap override is 2 cycles.

## Test plan
- Reset in PEND: hold decode1_pc=0x8000_0040, then assert rst in the cycle after capture. All outputs read 0 in the same cycle; after release the state is IDLE and epoch is 0.
- Simultaneous requests in IDLE: trap_pc=0x8000_1000, decode1_pc=0x8000_0200 and decode2_pc=0x8000_0300 all pulsed with cache_un_ready=0 and redir_ready=1. Next cycle: redir_pc=0x8000_1000, redir_src=11, flush_fetch=1, fetch_epoch=1, drop_cnt=2. The cycle after: IDLE, stall_fetch=0.
- Cache busy: decode2 pulse with decode2_pc=0x8000_0080 while cache_un_ready is high for 5 cycles. Expect stall_fetch=1 and redir_valid=0 for those 5 cycles, then redir_valid=1 with redir_pc=0x8000_0080 when cache_un_ready drops.
- Back-pressure: in PEND, hold redir_ready=0 for 3 cycles. redir_valid and redir_pc stay stable; after redir_ready=1 the block is in IDLE on the next cycle.
- Override: decode1 is pending (0x8000_0100), then decode2 pulses, giving drop_cnt=1. Next, trap pulses with trap_pc=0x8000_2000, giving redir_pc=0x8000_2000, redir_src=11, a second flush pulse and fetch_epoch=2. A trap repeated while the trap entry is held gives drop_cnt=2 and redir_pc unchanged.
- Wrap and saturation: 8 accepted redirects return fetch_epoch to 0. 300 dropped requests leave drop_cnt=255.

Source files
------------

// File: rtl/pc_redirect_arbiter.sv
// PC redirect arbiter: picks trap > decode1 > decode2, holds the winner while the icache is busy,
// and hands it to the PC over valid/ready. Flushes in-flight fetch and bumps the fetch epoch.
module pc_redirect_arbiter #(
    parameter int unsigned PC_W    = 64,
    parameter int unsigned EPOCH_W = 3,
    parameter int unsigned DROP_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trap_ena,
    input  logic [PC_W-1:0]    trap_pc,
    input  logic               decode1_ena,
    input  logic [PC_W-1:0]    decode1_pc,
    input  logic               decode2_ena,
    input  logic [PC_W-1:0]    decode2_pc,
    input  logic               cache_un_ready,
    output logic               redir_valid,
    output logic [PC_W-1:0]    redir_pc,
    output logic [1:0]         redir_src,
    input  logic               redir_ready,
    output logic               flush_fetch,
    output logic [EPOCH_W-1:0] fetch_epoch,
    output logic               stall_fetch,
    output logic [DROP_W-1:0]  drop_cnt
);

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    localparam logic [1:0] SrcNone    = 2'b00;
    localparam logic [1:0] SrcDecode2 = 2'b01;
    localparam logic [1:0] SrcDecode1 = 2'b10;
    localparam logic [1:0] SrcTrap    = 2'b11;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     held_pc_q, held_pc_d;
    logic [1:0]          held_src_q, held_src_d;
    logic                flush_q, flush_d;
    logic [EPOCH_W-1:0]  epoch_q, epoch_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic                handshake;
    logic [1:0]          drop_inc;
    logic [DROP_W:0]     drop_sum;

    assign redir_valid = (state_q == StPend) && !cache_un_ready;
    assign handshake   = redir_valid && redir_ready;
    assign redir_pc    = held_pc_q;
    assign redir_src   = held_src_q;
    assign flush_fetch = flush_q;
    assign fetch_epoch = epoch_q;
    assign stall_fetch = (state_q == StPend);
    assign drop_cnt    = drop_cnt_q;

    always_comb begin
        state_d    = state_q;
        held_pc_d  = held_pc_q;
        held_src_d = held_src_q;
        flush_d    = 1'b0;
        epoch_d    = epoch_q;
        drop_inc   = 2'd0;

        unique case (state_q)
            StIdle: begin
                if (trap_ena || decode1_ena || decode2_ena) begin
                    state_d = StPend;
                    flush_d = 1'b1;
                    epoch_d = epoch_q + {{(EPOCH_W-1){1'b0}}, 1'b1};
                    if (trap_ena) begin
                        held_pc_d  = trap_pc;
                        held_src_d = SrcTrap;
                        drop_inc   = {1'b0, decode1_ena} + {1'b0, decode2_ena};
                    end else if (decode1_ena) begin
                        held_pc_d  = decode1_pc;
                        held_src_d = SrcDecode1;
                        drop_inc   = {1'b0, decode2_ena};
                    end else begin
                        held_pc_d  = decode2_pc;
                        held_src_d = SrcDecode2;
                    end
                end
            end
            StPend: begin
                // Decode requests behind a pending redirect are wrong-path.
                drop_inc = {1'b0, decode1_ena} + {1'b0, decode2_ena};
                if (handshake) begin
                    state_d    = StIdle;
                    held_src_d = SrcNone;
                end
                if (trap_ena) begin
                    if (held_src_q != SrcTrap) begin
                        state_d    = StPend;
                        held_pc_d  = trap_pc;
                        held_src_d = SrcTrap;
                        flush_d    = 1'b1;
                        epoch_d    = epoch_q + {{(EPOCH_W-1){1'b0}}, 1'b1};
                    end else begin
                        drop_inc = drop_inc + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        drop_sum   = {1'b0, drop_cnt_q} + {{(DROP_W-1){1'b0}}, drop_inc};
        drop_cnt_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            held_pc_q  <= '0;
            held_src_q <= SrcNone;
            flush_q    <= 1'b0;
            epoch_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            held_pc_q  <= held_pc_d;
            held_src_q <= held_src_d;
            flush_q    <= flush_d;
            epoch_q    <= epoch_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_redirect_arbiter.sv
// Directed self-checking bench for pc_redirect_arbiter.
module tb_pc_redirect_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_ena, decode1_ena, decode2_ena;
    logic [63:0] trap_pc, decode1_pc, decode2_pc;
    logic        cache_un_ready, redir_ready;
    logic        redir_valid, flush_fetch, stall_fetch;
    logic [63:0] redir_pc;
    logic [1:0]  redir_src;
    logic [2:0]  fetch_epoch;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_redirect_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .trap_ena       (trap_ena),
        .trap_pc        (trap_pc),
        .decode1_ena    (decode1_ena),
        .decode1_pc     (decode1_pc),
        .decode2_ena    (decode2_ena),
        .decode2_pc     (decode2_pc),
        .cache_un_ready (cache_un_ready),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .redir_src      (redir_src),
        .redir_ready    (redir_ready),
        .flush_fetch    (flush_fetch),
        .fetch_epoch    (fetch_epoch),
        .stall_fetch    (stall_fetch),
        .drop_cnt       (drop_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        trap_ena    = 1'b0;
        decode1_ena = 1'b0;
        decode2_ena = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({redir_valid, flush_fetch, stall_fetch, redir_src, fetch_epoch, drop_cnt} !== 16'd0
            || redir_pc !== 64'd0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b flush=%b stall=%b src=%b epoch=%0d drop=%0d pc=%h",
                     redir_valid, flush_fetch, stall_fetch, redir_src, fetch_epoch, drop_cnt,
                     redir_pc);
        end
    endtask

    task automatic test_reset_in_pend();
        cache_un_ready = 1'b0;
        redir_ready    = 1'b0;
        decode1_pc     = 64'h8000_0040;
        decode1_ena    = 1'b1;
        step();
        clear_reqs();
        total++;
        if (stall_fetch !== 1'b1 || redir_pc !== 64'h8000_0040 || fetch_epoch !== 3'd1) begin
            bad++;
            $display("FAIL pend_capture: stall=%b pc=%h epoch=%0d, want 1 80000040 1",
                     stall_fetch, redir_pc, fetch_epoch);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({redir_valid, flush_fetch, stall_fetch, redir_src, fetch_epoch, drop_cnt} !== 16'd0
            || redir_pc !== 64'd0) begin
            bad++;
            $display("FAIL async_reset_outputs: valid=%b flush=%b stall=%b src=%b epoch=%0d pc=%h",
                     redir_valid, flush_fetch, stall_fetch, redir_src, fetch_epoch, redir_pc);
        end
        step();
        rst = 1'b0;
        step();
        total++;
        if (stall_fetch !== 1'b0 || fetch_epoch !== 3'd0 || redir_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: stall=%b epoch=%0d valid=%b, want 0 0 0",
                     stall_fetch, fetch_epoch, redir_valid);
        end
    endtask

    task automatic test_simultaneous();
        cache_un_ready = 1'b0;
        redir_ready    = 1'b1;
        trap_pc        = 64'h8000_1000;
        decode1_pc     = 64'h8000_0200;
        decode2_pc     = 64'h8000_0300;
        trap_ena       = 1'b1;
        decode1_ena    = 1'b1;
        decode2_ena    = 1'b1;
        step();
        clear_reqs();
        total++;
        if (redir_pc !== 64'h8000_1000 || redir_src !== 2'b11 || flush_fetch !== 1'b1
            || fetch_epoch !== 3'd1 || drop_cnt !== 8'd2 || redir_valid !== 1'b1) begin
            bad++;
            $display("FAIL simul_capture: pc=%h src=%b flush=%b epoch=%0d drop=%0d valid=%b",
                     redir_pc, redir_src, flush_fetch, fetch_epoch, drop_cnt, redir_valid);
        end
        step();
        total++;
        if (stall_fetch !== 1'b0 || redir_valid !== 1'b0 || flush_fetch !== 1'b0
            || redir_src !== 2'b00) begin
            bad++;
            $display("FAIL simul_after: stall=%b valid=%b flush=%b src=%b, want 0 0 0 00",
                     stall_fetch, redir_valid, flush_fetch, redir_src);
        end
    endtask

    task automatic test_cache_busy();
        cache_un_ready = 1'b1;
        redir_ready    = 1'b1;
        decode2_pc     = 64'h8000_0080;
        decode2_ena    = 1'b1;
        step();
        clear_reqs();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (stall_fetch !== 1'b1 || redir_valid !== 1'b0) begin
                bad++;
                $display("FAIL busy_cycle%0d: stall=%b valid=%b, want 1 0",
                         i, stall_fetch, redir_valid);
            end
            if (i < 4) step();
        end
        cache_un_ready = 1'b0;
        #1;
        total++;
        if (redir_valid !== 1'b1 || redir_pc !== 64'h8000_0080 || redir_src !== 2'b01) begin
            bad++;
            $display("FAIL busy_release: valid=%b pc=%h src=%b, want 1 80000080 01",
                     redir_valid, redir_pc, redir_src);
        end
        step();
        total++;
        if (stall_fetch !== 1'b0 || fetch_epoch !== 3'd2) begin
            bad++;
            $display("FAIL busy_done: stall=%b epoch=%0d, want 0 2", stall_fetch, fetch_epoch);
        end
    endtask

    task automatic test_back_pressure();
        cache_un_ready = 1'b0;
        redir_ready    = 1'b0;
        decode1_pc     = 64'h8000_0500;
        decode1_ena    = 1'b1;
        step();
        clear_reqs();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (redir_valid !== 1'b1 || redir_pc !== 64'h8000_0500 || stall_fetch !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%b pc=%h stall=%b, want 1 80000500 1",
                         i, redir_valid, redir_pc, stall_fetch);
            end
            step();
        end
        redir_ready = 1'b1;
        step();
        total++;
        if (stall_fetch !== 1'b0 || redir_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_done: stall=%b valid=%b, want 0 0", stall_fetch, redir_valid);
        end
        // A new request is taken in the very cycle after the handshake.
        decode2_pc  = 64'h8000_0600;
        decode2_ena = 1'b1;
        step();
        clear_reqs();
        total++;
        if (stall_fetch !== 1'b1 || redir_pc !== 64'h8000_0600 || flush_fetch !== 1'b1
            || fetch_epoch !== 3'd4) begin
            bad++;
            $display("FAIL back_to_back: stall=%b pc=%h flush=%b epoch=%0d, want 1 80000600 1 4",
                     stall_fetch, redir_pc, flush_fetch, fetch_epoch);
        end
        step();
    endtask

    task automatic test_override();
        do_reset();
        cache_un_ready = 1'b0;
        redir_ready    = 1'b0;
        decode1_pc     = 64'h8000_0100;
        decode1_ena    = 1'b1;
        step();
        clear_reqs();
        decode2_pc  = 64'h8000_0900;
        decode2_ena = 1'b1;
        step();
        clear_reqs();
        total++;
        if (drop_cnt !== 8'd1 || redir_pc !== 64'h8000_0100 || redir_src !== 2'b10
            || flush_fetch !== 1'b0) begin
            bad++;
            $display("FAIL ovr_drop_decode: drop=%0d pc=%h src=%b flush=%b, want 1 80000100 10 0",
                     drop_cnt, redir_pc, redir_src, flush_fetch);
        end
        trap_pc  = 64'h8000_2000;
        trap_ena = 1'b1;
        step();
        clear_reqs();
        total++;
        if (redir_pc !== 64'h8000_2000 || redir_src !== 2'b11 || flush_fetch !== 1'b1
            || fetch_epoch !== 3'd2) begin
            bad++;
            $display("FAIL ovr_trap: pc=%h src=%b flush=%b epoch=%0d, want 80002000 11 1 2",
                     redir_pc, redir_src, flush_fetch, fetch_epoch);
        end
        trap_pc  = 64'h8000_3000;
        trap_ena = 1'b1;
        step();
        clear_reqs();
        total++;
        if (drop_cnt !== 8'd2 || redir_pc !== 64'h8000_2000 || flush_fetch !== 1'b0
            || fetch_epoch !== 3'd2) begin
            bad++;
            $display("FAIL ovr_trap_again: drop=%0d pc=%h flush=%b epoch=%0d, want 2 80002000 0 2",
                     drop_cnt, redir_pc, flush_fetch, fetch_epoch);
        end
        redir_ready = 1'b1;
        step();
        // Trap arriving in the handshake cycle replaces the consumed decode entry.
        decode1_pc  = 64'h8000_0700;
        decode1_ena = 1'b1;
        step();
        clear_reqs();
        trap_pc  = 64'h8000_4000;
        trap_ena = 1'b1;
        step();
        clear_reqs();
        total++;
        if (stall_fetch !== 1'b1 || redir_pc !== 64'h8000_4000 || redir_src !== 2'b11
            || flush_fetch !== 1'b1 || fetch_epoch !== 3'd4) begin
            bad++;
            $display("FAIL trap_at_handshake: stall=%b pc=%h src=%b flush=%b epoch=%0d",
                     stall_fetch, redir_pc, redir_src, flush_fetch, fetch_epoch);
        end
        step();
        total++;
        if (stall_fetch !== 1'b0) begin
            bad++;
            $display("FAIL trap_issue: stall=%b, want 0", stall_fetch);
        end
    endtask

    task automatic test_wrap_saturate();
        logic [2:0] exp_epoch;
        do_reset();
        cache_un_ready = 1'b0;
        redir_ready    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            decode1_pc  = 64'h8000_0000 + 64'(i * 16);
            decode1_ena = 1'b1;
            step();
            clear_reqs();
            step();
            exp_epoch = 3'(i + 1);
            total++;
            if (fetch_epoch !== exp_epoch || stall_fetch !== 1'b0) begin
                bad++;
                $display("FAIL epoch_wrap%0d: epoch=%0d stall=%b, want %0d 0",
                         i, fetch_epoch, stall_fetch, exp_epoch);
            end
        end
        redir_ready = 1'b0;
        decode1_pc  = 64'h8000_5000;
        decode1_ena = 1'b1;
        step();
        for (int i = 0; i < 150; i++) begin
            decode1_ena = 1'b1;
            decode2_ena = 1'b1;
            step();
            if (i == 126) begin
                total++;
                if (drop_cnt !== 8'd254) begin
                    bad++;
                    $display("FAIL drop_254: drop=%0d, want 254", drop_cnt);
                end
            end
        end
        clear_reqs();
        total++;
        if (drop_cnt !== 8'd255 || redir_pc !== 64'h8000_5000) begin
            bad++;
            $display("FAIL drop_saturate: drop=%0d pc=%h, want 255 80005000", drop_cnt, redir_pc);
        end
    endtask

    initial begin
        rst            = 1'b1;
        trap_pc        = '0;
        decode1_pc     = '0;
        decode2_pc     = '0;
        cache_un_ready = 1'b0;
        redir_ready    = 1'b0;
        clear_reqs();
        test_reset();
        test_reset_in_pend();
        test_simultaneous();
        test_cache_busy();
        test_back_pressure();
        test_override();
        test_wrap_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
